// File: rtl/car_motion.sv
// Car position engine: on each frame tick, steps the car one move in the key direction.
// Before committing the move it probes the map memory along the car's leading edge for walls.
module car_motion #(
    parameter int         CAR_SIZE    = 8,
    parameter int         STEP        = 1,
    parameter int         START_X     = 8,
    parameter int         START_Y     = 56,
    parameter logic [8:0] WALL_COLOUR = 9'h000,
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        frameTick,
    input  logic        resetPos,
    input  logic        keyUp,
    input  logic        keyDown,
    input  logic        keyLeft,
    input  logic        keyRight,
    input  logic [8:0]  mapQ,
    output logic        mapRd,
    output logic [14:0] mapAddr,
    output logic [7:0]  nextX,
    output logic [6:0]  nextY,
    output logic [2:0]  dir,
    output logic        busy,
    output logic        stepDone,
    output logic        moved,
    output logic [2:0]  dbgState
);

    // Step handshake: a frameTick is accepted only while busy is low. Every accepted
    // tick produces exactly one stepDone pulse, and moved/nextX/nextY/dir are stable
    // during that pulse. Ticks that arrive while busy is high are dropped.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC   = 3'd1,
        PROBE  = 3'd2,
        DRAIN  = 3'd3,
        COMMIT = 3'd4
    } state_t;

    localparam int CNT_W = (CAR_SIZE > 1) ? $clog2(CAR_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CAR_SIZE - 1);
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;
    localparam logic signed [8:0] STEP_S = 9'(STEP);
    localparam logic signed [8:0] MAX_X  = 9'(SCREEN_W - CAR_SIZE);
    localparam logic signed [8:0] MAX_Y  = 9'(SCREEN_H - CAR_SIZE);
    localparam logic [14:0] EDGE_OFF = 15'(CAR_SIZE - 1);
    localparam logic [14:0] ROW_W    = 15'(SCREEN_W);
    localparam logic [7:0]  START_X8 = 8'(START_X);
    localparam logic [6:0]  START_Y7 = 7'(START_Y);

    state_t state, stateNext;

    logic [CNT_W-1:0] probeCnt, probeCntD;
    logic [7:0] candX, candXD;
    logic [6:0] candY, candYD;
    logic [1:0] candDir, candDirD;
    logic       candOk, candOkD;
    logic       wallFlag, wallD;
    logic       qValid, qValidD;
    logic       rpPending, rpD;

    logic [7:0]  nextXD;
    logic [6:0]  nextYD;
    logic [2:0]  dirD;
    logic        mapRdD, busyD, stepDoneD, movedD;
    logic [14:0] mapAddrD;

    logic              keyAny;
    logic [1:0]        keyDir;
    logic signed [8:0] curX, curY, calcX, calcY;
    logic              calcOk;
    logic              wallHit, commitNow, commitOk;

    // Address of probe idx on the leading edge of a car whose top-left is (x, y).
    function automatic logic [14:0] probeAddr(input logic [7:0] x, input logic [6:0] y,
                                              input logic [1:0] d, input logic [CNT_W-1:0] idx);
        logic [14:0] px;
        logic [14:0] py;
        px = 15'(x);
        py = 15'(y);
        case (d)
            DIR_UP:    px = px + 15'(idx);
            DIR_DOWN:  begin px = px + 15'(idx); py = py + EDGE_OFF; end
            DIR_LEFT:  py = py + 15'(idx);
            default:   begin px = px + EDGE_OFF; py = py + 15'(idx); end
        endcase
        return py * ROW_W + px;
    endfunction

    assign dbgState = state;

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (frameTick && !resetPos) stateNext = CALC;
            CALC:    stateNext = keyAny ? PROBE : COMMIT;
            PROBE:   if (probeCnt == LAST_IDX) stateNext = DRAIN;
            DRAIN:   stateNext = COMMIT;
            COMMIT:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Candidate position, evaluated from the keys while in CALC.
    always_comb begin
        keyAny = keyUp | keyDown | keyLeft | keyRight;
        if (keyUp)        keyDir = DIR_UP;
        else if (keyDown) keyDir = DIR_DOWN;
        else if (keyLeft) keyDir = DIR_LEFT;
        else              keyDir = DIR_RIGHT;
        curX  = $signed({1'b0, nextX});
        curY  = $signed({2'b00, nextY});
        calcX = curX;
        calcY = curY;
        case (keyDir)
            DIR_UP:    calcY = curY - STEP_S;
            DIR_DOWN:  calcY = curY + STEP_S;
            DIR_LEFT:  calcX = curX - STEP_S;
            default:   calcX = curX + STEP_S;
        endcase
        calcOk = !calcX[8] && !calcY[8] && (calcX <= MAX_X) && (calcY <= MAX_Y);
    end

    always_comb begin
        nextXD    = nextX;
        nextYD    = nextY;
        dirD      = dir;
        mapRdD    = 1'b0;
        mapAddrD  = mapAddr;
        busyD     = (stateNext != IDLE);
        stepDoneD = 1'b0;
        movedD    = moved;
        candXD    = candX;
        candYD    = candY;
        candDirD  = candDir;
        candOkD   = candOk;
        probeCntD = probeCnt;
        wallD     = wallFlag;
        qValidD   = mapRd;
        rpD       = rpPending | (resetPos && (state != IDLE));
        wallHit   = qValid && (mapQ == WALL_COLOUR);
        commitNow = 1'b0;
        commitOk  = 1'b0;
        case (state)
            IDLE: begin
                rpD = 1'b0;
                if (resetPos) begin
                    nextXD = START_X8;
                    nextYD = START_Y7;
                    dirD   = 3'd0;
                end
            end
            CALC: begin
                wallD     = 1'b0;
                probeCntD = '0;
                if (keyAny) begin
                    dirD     = {1'b0, keyDir};
                    candXD   = calcX[7:0];
                    candYD   = calcY[6:0];
                    candDirD = keyDir;
                    candOkD  = calcOk;
                    mapRdD   = calcOk;
                    if (calcOk) mapAddrD = probeAddr(calcX[7:0], calcY[6:0], keyDir, '0);
                end else begin
                    commitNow = 1'b1;
                end
            end
            PROBE: begin
                if (wallHit) wallD = 1'b1;
                if (probeCnt != LAST_IDX) begin
                    probeCntD = probeCnt + CNT_W'(1);
                    mapRdD    = candOk;
                    if (candOk) mapAddrD = probeAddr(candX, candY, candDir, probeCnt + CNT_W'(1));
                end
            end
            DRAIN: begin
                // The last probe's data lands here, so fold it in directly.
                commitNow = 1'b1;
                commitOk  = candOk && !(wallFlag || wallHit);
            end
            COMMIT: begin
                rpD = 1'b0;
                if (resetPos) begin
                    nextXD = START_X8;
                    nextYD = START_Y7;
                    dirD   = 3'd0;
                end
            end
            default: ;
        endcase
        if (commitNow) begin
            stepDoneD = 1'b1;
            rpD       = 1'b0;
            if (rpPending || resetPos) begin
                nextXD = START_X8;
                nextYD = START_Y7;
                dirD   = 3'd0;
                movedD = 1'b0;
            end else if (commitOk) begin
                nextXD = candX;
                nextYD = candY;
                movedD = 1'b1;
            end else begin
                movedD = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            nextX     <= START_X8;
            nextY     <= START_Y7;
            dir       <= 3'd0;
            mapRd     <= 1'b0;
            mapAddr   <= '0;
            busy      <= 1'b0;
            stepDone  <= 1'b0;
            moved     <= 1'b0;
            candX     <= '0;
            candY     <= '0;
            candDir   <= '0;
            candOk    <= 1'b0;
            probeCnt  <= '0;
            wallFlag  <= 1'b0;
            qValid    <= 1'b0;
            rpPending <= 1'b0;
        end else begin
            nextX     <= nextXD;
            nextY     <= nextYD;
            dir       <= dirD;
            mapRd     <= mapRdD;
            mapAddr   <= mapAddrD;
            busy      <= busyD;
            stepDone  <= stepDoneD;
            moved     <= movedD;
            candX     <= candXD;
            candY     <= candYD;
            candDir   <= candDirD;
            candOk    <= candOkD;
            probeCnt  <= probeCntD;
            wallFlag  <= wallD;
            qValid    <= qValidD;
            rpPending <= rpD;
        end
    end

endmodule

// File: tb/tb_car_motion.sv
// Bench for car_motion: a map memory model, a behavioural step model feeding
// expected-result and expected-probe queues, and a negedge monitor that checks them.
module tb_car_motion;

    localparam int CS = 8;
    localparam int SW = 160;
    localparam int SH = 120;
    localparam int SX = 8;
    localparam int SY = 56;
    localparam int W  = 27;
    localparam int PW = 23;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        frameTick = 1'b0;
    logic        resetPos = 1'b0;
    logic        keyUp = 1'b0;
    logic        keyDown = 1'b0;
    logic        keyLeft = 1'b0;
    logic        keyRight = 1'b0;
    logic [8:0]  mapQ = 9'h155;
    logic        mapRd;
    logic [14:0] mapAddr;
    logic [7:0]  nextX;
    logic [6:0]  nextY;
    logic [2:0]  dir;
    logic        busy;
    logic        stepDone;
    logic        moved;
    logic [2:0]  dbgState;

    always #5 clock = ~clock;

    car_motion dut (
        .clock(clock), .resetn(resetn), .frameTick(frameTick), .resetPos(resetPos),
        .keyUp(keyUp), .keyDown(keyDown), .keyLeft(keyLeft), .keyRight(keyRight),
        .mapQ(mapQ), .mapRd(mapRd), .mapAddr(mapAddr), .nextX(nextX), .nextY(nextY),
        .dir(dir), .busy(busy), .stepDone(stepDone), .moved(moved), .dbgState(dbgState)
    );

    logic [8:0] mapMem [0:SW*SH-1];
    always @(posedge clock) mapQ <= mapRd ? mapMem[mapAddr] : 9'h155;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tickCyc = 0;
    int doneCnt = 0;
    int nChecks = 0;
    int nFails = 0;
    int modelX = SX;
    int modelY = SY;
    int modelDir = 0;
    logic [W-1:0]  exp_q[$];
    logic [PW-1:0] probe_q[$];
    logic [W-1:0]  expItem;
    logic [PW-1:0] probeItem;
    logic          prevDone = 1'b0;
    logic [3:0]    m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        if (obs !== expv) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Behavioural step model: queues expected probes and the expected step result.
    task automatic pushStep(input logic u, input logic d, input logic l, input logic r,
                            input logic rp, input int probeLimit, input logic pushResult);
        int cx, cy, kd, px, py, lat;
        logic inb, wall, mv;
        cx = modelX; cy = modelY; wall = 1'b0; inb = 1'b0; mv = 1'b0;
        px = 0; py = 0;
        if (!(u | d | l | r)) begin
            lat = 2;
            kd = modelDir;
        end else begin
            lat = CS + 3;
            kd = u ? 0 : (d ? 2 : (l ? 3 : 1));
            case (kd)
                0: cy = cy - 1;
                1: cx = cx + 1;
                2: cy = cy + 1;
                default: cx = cx - 1;
            endcase
            inb = (cx >= 0) && (cy >= 0) && (cx <= SW - CS) && (cy <= SH - CS);
            for (int i = 0; i < CS; i++) begin
                case (kd)
                    0: begin px = cx + i; py = cy; end
                    2: begin px = cx + i; py = cy + CS - 1; end
                    3: begin px = cx; py = cy + i; end
                    default: begin px = cx + CS - 1; py = cy + i; end
                endcase
                if (inb) begin
                    if (i < probeLimit) probe_q.push_back({8'(2 + i), 15'(py * SW + px)});
                    if (mapMem[py * SW + px] == 9'h000) wall = 1'b1;
                end
            end
            mv = inb && !wall;
        end
        if (rp) begin
            cx = SX; cy = SY; kd = 0; mv = 1'b0;
        end else if (!mv) begin
            cx = modelX; cy = modelY;
        end
        modelX = cx; modelY = cy; modelDir = kd;
        if (pushResult) exp_q.push_back({8'(lat), mv, 8'(cx), 7'(cy), 3'(kd)});
    endtask

    task automatic doStep(input logic u, input logic d, input logic l, input logic r,
                          input int extraTick, input int rpAt);
        int startCnt;
        pushStep(u, d, l, r, rpAt >= 0, CS, 1'b1);
        @(negedge clock);
        keyUp = u; keyDown = d; keyLeft = l; keyRight = r;
        frameTick = 1'b1;
        tickCyc = cyc;
        startCnt = doneCnt;
        for (int k = 1; k <= 40 && doneCnt == startCnt; k++) begin
            @(negedge clock);
            frameTick = (k == extraTick);
            resetPos = (k == rpAt);
        end
        if (doneCnt == startCnt) begin
            check("stepTimeout", 32'd0, 32'd1);
            exp_q.delete();
            probe_q.delete();
        end
        keyUp = 1'b0; keyDown = 1'b0; keyLeft = 1'b0; keyRight = 1'b0;
        frameTick = 1'b0; resetPos = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (mapRd) begin
            if (probe_q.size() == 0) begin
                check("probeExtra", {17'd0, mapAddr}, 32'hFFFF_FFFF);
            end else begin
                probeItem = probe_q.pop_front();
                check("probeAddr", {17'd0, mapAddr}, {17'd0, probeItem[14:0]});
                check("probeCycle", cyc - tickCyc, {24'd0, probeItem[22:15]});
            end
        end
        if (stepDone) begin
            if (exp_q.size() == 0) begin
                check("unexpectedStep", 32'd1, 32'd0);
            end else begin
                expItem = exp_q.pop_front();
                check("stepLatency", cyc - tickCyc, {24'd0, expItem[26:19]});
                check("stepMoved", {31'd0, moved}, {31'd0, expItem[18]});
                check("stepX", {24'd0, nextX}, {24'd0, expItem[17:10]});
                check("stepY", {25'd0, nextY}, {25'd0, expItem[9:3]});
                check("stepDir", {29'd0, dir}, {29'd0, expItem[2:0]});
                check("busyAtDone", {31'd0, busy}, 32'd1);
                check("probesDrained", probe_q.size(), 32'd0);
                probe_q.delete();
            end
            doneCnt++;
        end
        if (prevDone) check("busyFall", {31'd0, busy}, 32'd0);
        prevDone = stepDone;
    end

    initial begin
        for (int i = 0; i < SW * SH; i++) mapMem[i] = 9'h1FF;
        mapMem[55 * SW + 11] = 9'h000;

        // Clock/reset block
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        check("rstNextX", {24'd0, nextX}, 32'd8);
        check("rstNextY", {25'd0, nextY}, 32'd56);
        check("rstDir", {29'd0, dir}, 32'd0);
        check("rstBusy", {31'd0, busy}, 32'd0);
        check("rstStepDone", {31'd0, stepDone}, 32'd0);
        check("rstMoved", {31'd0, moved}, 32'd0);
        check("rstMapRd", {31'd0, mapRd}, 32'd0);
        check("rstMapAddr", {17'd0, mapAddr}, 32'd0);
        resetn = 1'b1;
        repeat (20) @(negedge clock);
        check("idleBusy", {31'd0, busy}, 32'd0);

        // Open-map step right
        doStep(1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        check("rightX", {24'd0, nextX}, 32'd9);
        check("rightDir", {29'd0, dir}, 32'd1);

        // resetPos together with frameTick in IDLE: reload only, no step
        @(negedge clock);
        resetPos = 1'b1; frameTick = 1'b1;
        @(negedge clock);
        resetPos = 1'b0; frameTick = 1'b0;
        repeat (3) @(negedge clock);
        check("reloadX", {24'd0, nextX}, 32'd8);
        check("reloadY", {25'd0, nextY}, 32'd56);
        check("reloadDir", {29'd0, dir}, 32'd0);
        check("reloadBusy", {31'd0, busy}, 32'd0);
        modelX = SX; modelY = SY; modelDir = 0;

        // Up into a wall pixel at (11,55)
        doStep(1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
        check("wallY", {25'd0, nextY}, 32'd56);
        check("wallMoved", {31'd0, moved}, 32'd0);
        check("wallDir", {29'd0, dir}, 32'd0);

        // Walk to the left edge, then push against it
        for (int i = 0; i < SX; i++) doStep(1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        check("edgeX0", {24'd0, nextX}, 32'd0);
        doStep(1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        check("leftBlockX", {24'd0, nextX}, 32'd0);
        check("leftBlockDir", {29'd0, dir}, 32'd3);

        // Up+right with a stray tick mid-step
        doStep(1'b1, 1'b0, 1'b0, 1'b1, 5, -1);
        check("comboY", {25'd0, nextY}, 32'd55);
        check("comboDir", {29'd0, dir}, 32'd0);

        // No key pressed
        doStep(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);

        // resetPos during a step
        doStep(1'b0, 1'b1, 1'b0, 1'b0, -1, 4);
        check("rpX", {24'd0, nextX}, 32'd8);
        check("rpY", {25'd0, nextY}, 32'd56);

        // Random walls and random key combinations
        repeat (30) mapMem[$urandom_range(70, 40) * SW + $urandom_range(40, 0)] = 9'h000;
        for (int i = 0; i < 12; i++) begin
            m = 4'($urandom_range(15, 0));
            doStep(m[0], m[1], m[2], m[3], -1, -1);
        end

        // Reset in the middle of a step
        pushStep(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5, 1'b0);
        @(negedge clock);
        keyRight = 1'b1; frameTick = 1'b1;
        tickCyc = cyc;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            frameTick = 1'b0;
            if (k == 6) resetn = 1'b0;
        end
        @(negedge clock);
        resetn = 1'b1;
        keyRight = 1'b0;
        check("midRstBusy", {31'd0, busy}, 32'd0);
        check("midRstDone", {31'd0, stepDone}, 32'd0);
        check("midRstX", {24'd0, nextX}, 32'd8);
        check("midRstY", {25'd0, nextY}, 32'd56);
        modelX = SX; modelY = SY; modelDir = 0;
        repeat (20) @(negedge clock);

        check("expQueueEmpty", exp_q.size(), 32'd0);
        check("probeQueueEmpty", probe_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
